monty_reduce_iter: RTL and testbench
====================================

# monty_reduce_iter

Iterative Montgomery reduction stage for moduli of the form q = qH·2^W + 1, with W = LOGQ − LOGQH. It accepts a double-width product T and performs ROUNDS word-serial reduction rounds of W bits each, producing C ≡ T·2^(−W·ROUNDS) (mod q) with C < 2q. It sits directly upstream of correction_u and drives that stage's LOGC-bit C input. Valid/ready handshakes on both sides; one operation in flight at a time.

## Interface
- LOGQ, 64, modulus width
- LOGQH, 17, width of qH; W = LOGQ − LOGQH, must be ≥ 1
- ROUNDS, 2, reduction rounds; R = 2^(W·ROUNDS), R ≥ 2^LOGQ required
- LOGC, LOGQ+1, output width
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept
- T_in  in  2·LOGQ  product to reduce, legal range T_in < q·R
- qH  in  LOGQH  modulus high part, sampled on accept
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- C  out  LOGC  reduced result, C < 2q
- err  out  1  range-check flag, qualified by out_valid

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid && in_ready: latch T_in into accumulator A (2·LOGQ+1 bits), latch qH, round counter k=0, go RUN.
- RUN, one round per cycle, combinational step: L = A[W−1:0]; m = (2^W − L) mod 2^W; c = (L != 0); A ← (A >> W) + c + m·qH. k increments; after round ROUNDS−1 go DONE.
- Arithmetic: m·qH is W×LOGQH unsigned; all sums unsigned, no truncation inside A; A bounded by max(T_in>>W, q) + 2^W·qH and fits 2·LOGQ+1 bits.
- DONE: out_valid=1, C = A[LOGC−1:0]. On out_ready go IDLE. C, err held stable while out_valid && !out_ready.
- in_ready=0 in RUN and DONE; input side never accepts while a result is pending.
- Illegal T_in ≥ q·R: result is unspecified without range check; no hang, FSM completes normally.
- Reset (any state, including mid-RUN): state=IDLE, in_ready=1, out_valid=0, C=0, err=0, A=0, k=0; in-flight operation discarded.

## Timing
- Accept edge = cycle 0. Rounds on edges 1..ROUNDS. out_valid high from cycle ROUNDS+1 (after accept edge: ROUNDS+1 cycles).
- Transfer when out_valid && out_ready; in_ready returns next cycle. Minimum initiation interval ROUNDS+2 cycles.
- out_ready may be held high in advance; no combinational path in_valid→in_ready or out_ready→out_valid.

## Configuration
- MONTY_REDUCE_RANGE_CHK_EN defined: on accept, compare T_in against q·R (q built as {qH, 0…0, 1}); register result; err driven with out_valid when T_in ≥ q·R. Result C still produced.
- Undefined: comparator absent, err tied 0.

## Structure
- Package monty_pkg: state enum (IDLE/RUN/DONE), function monty_reduce_lat(ROUNDS) = ROUNDS+1, function for round-counter width $clog2(ROUNDS+1).
- Sub-module monty_round_u: combinational single round (A, qH → A'), parameterised on LOGQ, LOGQH; instantiated once and reused each cycle.

## Test plan
Bench config LOGQ=8, LOGQH=4 (W=4), ROUNDS=2, qH=6 → q=97, R=256.
- T_in=1 → C=36 (R⁻¹ mod 97), out_valid exactly 3 cycles after accept, err=0.
- T_in=24831 (q·R−1) → intermediate A after round 1 = 1558, C=158 (<194); err=0.
- T_in=0 → C=0; then back-to-back request with in_valid held high: second accept occurs on first cycle in_ready returns.
- out_ready low 5 cycles in DONE → C=36 and out_valid held, in_ready=0 throughout; release → single transfer.
- rstn asserted during RUN → outputs zero immediately, in_ready=1; next operation T_in=1 yields C=36.
- MONTY_REDUCE_RANGE_CHK_EN: T_in=24832 → err=1 with out_valid; T_in=24831 → err=0. Without macro err=0 for both.

Source files
------------

// File: rtl/monty_pkg.sv
// Shared types and helpers for the iterative Montgomery reduction stage.
package monty_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Cycles from the accept edge to the first edge at which out_valid is seen high.
  function automatic int unsigned monty_reduce_lat(input int unsigned rounds);
    return rounds + 1;
  endfunction

  // Width of the round counter.
  function automatic int unsigned monty_cnt_w(input int unsigned rounds);
    return (rounds < 2) ? 1 : $clog2(rounds + 1);
  endfunction

endpackage

// File: rtl/monty_reduce_iter_if.sv
// Operand/result handshake bundle for monty_reduce_iter.
interface monty_reduce_iter_if #(
  parameter int unsigned LOGQ  = 64,
  parameter int unsigned LOGQH = 17,
  parameter int unsigned LOGC  = LOGQ + 1
);
  logic                in_valid;
  logic                in_ready;
  logic [2*LOGQ-1:0]   T_in;
  logic [LOGQH-1:0]    qH;
  logic                out_valid;
  logic                out_ready;
  logic [LOGC-1:0]     C;
  logic                err;

  modport master (
    output in_valid, T_in, qH, out_ready,
    input  in_ready, out_valid, C, err
  );

  modport slave (
    input  in_valid, T_in, qH, out_ready,
    output in_ready, out_valid, C, err
  );
endinterface

// File: rtl/monty_reduce_iter_round.sv
// One word-serial Montgomery round for q = qH*2^W + 1:
// A' = (A >> W) + (L != 0) + m*qH, with L = A mod 2^W and m = -L mod 2^W.
module monty_round_u #(
  parameter int unsigned LOGQ  = 64,
  parameter int unsigned LOGQH = 17
) (
  input  logic [2*LOGQ:0]  a_in,
  input  logic [LOGQH-1:0] qh,
  output logic [2*LOGQ:0]  a_out
);
  localparam int unsigned W  = LOGQ - LOGQH;
  localparam int unsigned AW = 2 * LOGQ + 1;
  localparam int unsigned MW = W + LOGQH;

  logic [W-1:0]  l;
  logic [W-1:0]  m;
  logic          c;
  logic [MW-1:0] mq;

  // Low word is cancelled exactly by m*q; the +c is the carry out of L + m.
  always_comb begin
    l     = a_in[W-1:0];
    m     = ~l + W'(1);
    c     = |l;
    mq    = MW'(m) * MW'(qh);
    a_out = (a_in >> W) + AW'(c) + AW'(mq);
  end
endmodule

// File: rtl/monty_reduce_iter.sv
// Iterative Montgomery reduction: C = T * 2^(-W*ROUNDS) mod q, C < 2q.
// Optional range check enabled by defining MONTY_REDUCE_RANGE_CHK_EN.
module monty_reduce_iter
  import monty_pkg::*;
#(
  parameter int unsigned LOGQ   = 64,
  parameter int unsigned LOGQH  = 17,
  parameter int unsigned ROUNDS = 2,
  parameter int unsigned LOGC   = LOGQ + 1
) (
  input  logic               clk,
  input  logic               rstn,
  monty_reduce_iter_if.slave bus
);
  localparam int unsigned W  = LOGQ - LOGQH;
  localparam int unsigned AW = 2 * LOGQ + 1;
  localparam int unsigned KW = monty_cnt_w(ROUNDS);

  state_t            state;
  logic [AW-1:0]     acc;
  logic [AW-1:0]     acc_nxt;
  logic [LOGQH-1:0]  qh_q;
  logic [KW-1:0]     k;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [LOGC-1:0]   c_q;
  logic              last;

  monty_round_u #(
    .LOGQ  (LOGQ),
    .LOGQH (LOGQH)
  ) u_round (
    .a_in  (acc),
    .qh    (qh_q),
    .a_out (acc_nxt)
  );

  assign last = (k == KW'(ROUNDS - 1));

  // Control FSM, accumulator and registered handshake outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      acc         <= '0;
      qh_q        <= '0;
      k           <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      c_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            acc        <= AW'(bus.T_in);
            qh_q       <= bus.qH;
            k          <= '0;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          k   <= k + KW'(1);
          if (last) begin
            c_q         <= acc_nxt[LOGC-1:0];
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.C         = c_q;

`ifdef MONTY_REDUCE_RANGE_CHK_EN
  localparam int unsigned QRW = LOGQ + W * ROUNDS + 1;

  logic [QRW-1:0] qr;
  logic           over;
  logic           chk_q;
  logic           err_q;

  // Limit q*R with q = {qH, 0..0, 1}; compared against the incoming operand.
  always_comb begin
    qr   = ((QRW'(bus.qH) << W) | QRW'(1)) << (W * ROUNDS);
    over = (QRW'(bus.T_in) >= qr);
  end

  // Range flag captured on accept, presented together with the result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chk_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && bus.in_valid) chk_q <= over;
      if (state == RUN && last) err_q <= chk_q;
      else if (state == DONE && bus.out_ready) err_q <= 1'b0;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_monty_reduce_iter.sv
// Self-checking bench for monty_reduce_iter (LOGQ=8, LOGQH=4, ROUNDS=2).
module tb_monty_reduce_iter;
  localparam int LOGQ   = 8;
  localparam int LOGQH  = 4;
  localparam int ROUNDS = 2;
  localparam int LOGC   = LOGQ + 1;
  localparam int W      = LOGQ - LOGQH;
  localparam int R      = 1 << (W * ROUNDS);

  logic clk = 1'b0;
  logic rstn = 1'b0;

  monty_reduce_iter_if #(.LOGQ(LOGQ), .LOGQH(LOGQH), .LOGC(LOGC)) bus ();

  monty_reduce_iter #(
    .LOGQ   (LOGQ),
    .LOGQH  (LOGQH),
    .ROUNDS (ROUNDS),
    .LOGC   (LOGC)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Handshake monitor: cycle stamps of accepts and transfers.
  int cyc = 0;
  int acc_q[$];
  int xfer_q[$];
  int xfer_c[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rstn && bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
    if (rstn && bus.out_valid && bus.out_ready) begin
      xfer_q.push_back(cyc);
      xfer_c.push_back(int'(bus.C));
    end
  end

  // Whole-R Montgomery reference: C = (T + M*q) / R, M = -T * q^-1 mod R.
  function automatic int model_c(input int t, input int qh);
    int q;
    int qinv;
    int mm;
    q = qh * (1 << W) + 1;
    qinv = 0;
    for (int x = 1; x < R; x += 2)
      if ((x * q) % R == 1) qinv = x;
    mm = (R - (t * qinv) % R) % R;
    return (t + mm * q) / R;
  endfunction

  task automatic send(input int t, input int qh, input bit keep);
    int n;
    n = 0;
    @(negedge clk);
    bus.T_in = 16'(t);
    bus.qH = 4'(qh);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_seen", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.in_valid = keep;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (bus.out_valid) break;
    end
    check("out_valid_seen", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int n;
    int a0;
    int x0;
    int qh;
    int t;
    int q;
    int d;
    bit illegal;
    bit exp_err;
    bit chk_on;

`ifdef MONTY_REDUCE_RANGE_CHK_EN
    chk_on = 1'b1;
`else
    chk_on = 1'b0;
`endif

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.T_in = '0;
    bus.qH = '0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_c", 64'(bus.C), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    rstn = 1'b1;

    // T=1 gives R^-1 mod 97 = 36
    send(1, 6, 1'b0);
    wait_valid(n);
    check("latency", 64'(n), 64'(ROUNDS + 1));
    check("t1_c", 64'(bus.C), 64'd36);
    check("t1_err", 64'(bus.err), 64'd0);
    take();
    check("after_xfer_valid", 64'(bus.out_valid), 64'd0);
    check("after_xfer_ready", 64'(bus.in_ready), 64'd1);

    // q*R - 1: largest legal operand
    send(24831, 6, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("acc_round1", 64'(dut.acc), 64'd1558);
    wait_valid(n);
    check("max_c", 64'(bus.C), 64'd158);
    check("max_err", 64'(bus.err), 64'd0);
    take();

    // Back-to-back with in_valid and out_ready both held high
    a0 = acc_q.size();
    x0 = xfer_q.size();
    @(negedge clk);
    bus.T_in = '0;
    bus.qH = 4'd6;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    n = 0;
    while (acc_q.size() < a0 + 2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    check("b2b_accepts", 64'(acc_q.size() - a0), 64'd2);
    if (acc_q.size() >= a0 + 2 && xfer_q.size() >= x0 + 1) begin
      check("b2b_ii", 64'(acc_q[a0+1] - acc_q[a0]), 64'(ROUNDS + 2));
      check("b2b_reaccept", 64'(acc_q[a0+1] - xfer_q[x0]), 64'd1);
      check("b2b_c0", 64'(xfer_c[x0]), 64'd0);
    end
    repeat (8) @(negedge clk);
    check("b2b_xfers", 64'(xfer_q.size() - x0), 64'd2);
    if (xfer_c.size() >= x0 + 2) check("b2b_c1", 64'(xfer_c[x0+1]), 64'd0);
    bus.out_ready = 1'b0;

    // Backpressure: result held for 5 cycles
    send(1, 6, 1'b0);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_c", 64'(bus.C), 64'd36);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
    end
    x0 = xfer_q.size();
    bus.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    bus.out_ready = 1'b0;
    check("hold_single_xfer", 64'(xfer_q.size() - x0), 64'd1);

    // Asynchronous reset in the middle of RUN
    send(1, 6, 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_c", 64'(bus.C), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("mid_rst_err", 64'(bus.err), 64'd0);
    check("mid_rst_acc", 64'(dut.acc), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    send(1, 6, 1'b0);
    wait_valid(n);
    check("post_rst_c", 64'(bus.C), 64'd36);
    take();

    // First illegal operand q*R
    send(24832, 6, 1'b0);
    wait_valid(n);
    check("illegal_err", 64'(bus.err), 64'(chk_on));
    take();

    // Randomized operands, mostly legal
    for (int i = 0; i < 40; i++) begin
      qh = int'($urandom_range(1, 15));
      q = qh * (1 << W) + 1;
      illegal = ($urandom_range(0, 3) == 0) && (q * R <= 65535);
      if (illegal) t = int'($urandom_range(q * R, 65535));
      else t = int'($urandom_range(0, q * R - 1));
      exp_err = illegal & chk_on;
      send(t, qh, 1'b0);
      wait_valid(n);
      check("rnd_latency", 64'(n), 64'(ROUNDS + 1));
      if (!illegal) check("rnd_c", 64'(bus.C), 64'(model_c(t, qh)));
      check("rnd_err", 64'(bus.err), 64'(exp_err));
      d = int'($urandom_range(0, 3));
      repeat (d) @(negedge clk);
      take();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
